// File: rtl/bus_ep_pkg.sv
// Shared types and packet field helpers for the parallel-bus device endpoint.
package bus_ep_pkg;

  localparam int STAT_W = 16;
  localparam int MAX_W  = 256;

  typedef enum logic [1:0] {TX_IDLE, TX_PUSH, TX_GAP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_HOLD} rx_state_e;

  // Callers zero-extend the packet to MAX_W and truncate the result back to id_w / payload width.
  function automatic logic [MAX_W-1:0] get_dst(input logic [MAX_W-1:0] pkt, input int bits, input int id_w);
    return (pkt >> (bits - id_w)) & ~({MAX_W{1'b1}} << id_w);
  endfunction

  function automatic logic [MAX_W-1:0] get_payload(input logic [MAX_W-1:0] pkt, input int bits, input int id_w);
    return pkt & ~({MAX_W{1'b1}} << (bits - id_w));
  endfunction

endpackage

// File: rtl/bus_ep_sat_cnt.sv
// Saturating event counter with synchronous clear.
module bus_ep_sat_cnt
  import bus_ep_pkg::*;
#(
  parameter int W = STAT_W
)(
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/bus_dev_endpoint.sv
// Device-side endpoint for one parallel-bus node: paced TX push, ID-filtered RX pop.
// Define BUS_EP_STATS_EN to add the tx_cnt / rx_cnt / drop_cnt statistics ports.
module bus_dev_endpoint
  import bus_ep_pkg::*;
#(
  parameter int              bits  = 65,
  parameter int              id_w  = 8,
  parameter logic [id_w-1:0] id    = '0,
  parameter logic [id_w-1:0] bdcst = {id_w{1'b1}},
  parameter int              gap   = 2
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [id_w-1:0]      tx_dst,
  input  logic [bits-id_w-1:0] tx_payload,
  output logic                 push,
  output logic [bits-1:0]      D_push,
  input  logic                 pndng,
  output logic                 pop,
  input  logic [bits-1:0]      D_pop,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_src_bcst,
  output logic [bits-id_w-1:0] rx_payload
`ifdef BUS_EP_STATS_EN
  ,
  output logic [STAT_W-1:0]    tx_cnt,
  output logic [STAT_W-1:0]    rx_cnt,
  output logic [STAT_W-1:0]    drop_cnt
`endif
);

  localparam int PAY_W = bits - id_w;

  tx_state_e         tx_state, tx_state_nxt;
  logic [7:0]        gap_cnt, gap_cnt_nxt;
  logic              tx_ready_nxt, push_nxt, tx_accept;
  logic [bits-1:0]   d_push_nxt;

  rx_state_e         rx_state, rx_state_nxt;
  logic [bits-1:0]   rx_buf;
  logic [id_w-1:0]   rx_dst;
  logic              rx_hit, rx_load;
  logic              pop_nxt, rx_valid_nxt, rx_bcst_nxt;
  logic [PAY_W-1:0]  rx_payload_nxt;

  assign tx_accept = tx_ready && tx_valid;

  always_comb begin
    tx_state_nxt = tx_state;
    gap_cnt_nxt  = gap_cnt;
    tx_ready_nxt = 1'b0;
    push_nxt     = 1'b0;
    d_push_nxt   = D_push;
    case (tx_state)
      TX_IDLE: begin
        tx_ready_nxt = 1'b1;
        if (tx_accept) begin
          tx_state_nxt = TX_PUSH;
          push_nxt     = 1'b1;
          tx_ready_nxt = 1'b0;
          d_push_nxt   = {tx_dst, tx_payload};
        end
      end
      TX_PUSH: begin
        if (gap == 0) begin
          tx_state_nxt = TX_IDLE;
          tx_ready_nxt = 1'b1;
        end else begin
          tx_state_nxt = TX_GAP;
          gap_cnt_nxt  = 8'(gap);
        end
      end
      TX_GAP: begin
        if (gap_cnt <= 8'd1) begin
          tx_state_nxt = TX_IDLE;
          tx_ready_nxt = 1'b1;
        end else begin
          gap_cnt_nxt  = gap_cnt - 8'd1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      gap_cnt  <= '0;
      tx_ready <= 1'b0;
      push     <= 1'b0;
      D_push   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      gap_cnt  <= gap_cnt_nxt;
      tx_ready <= tx_ready_nxt;
      push     <= push_nxt;
      D_push   <= d_push_nxt;
    end
  end

  assign rx_dst = id_w'(get_dst(MAX_W'(rx_buf), bits, id_w));
  assign rx_hit = (rx_dst == id) || (rx_dst == bdcst);

  always_comb begin
    rx_state_nxt   = rx_state;
    rx_load        = 1'b0;
    pop_nxt        = 1'b0;
    rx_valid_nxt   = 1'b0;
    rx_bcst_nxt    = rx_src_bcst;
    rx_payload_nxt = rx_payload;
    case (rx_state)
      RX_IDLE: begin
        if (pndng) begin
          rx_state_nxt = RX_POP;
          rx_load      = 1'b1;
          pop_nxt      = 1'b1;
        end
      end
      // pndng still reflects the packet being popped here, so it is not looked at
      RX_POP: begin
        if (rx_hit) begin
          rx_state_nxt   = RX_HOLD;
          rx_valid_nxt   = 1'b1;
          rx_bcst_nxt    = (rx_dst == bdcst);
          rx_payload_nxt = PAY_W'(get_payload(MAX_W'(rx_buf), bits, id_w));
        end else begin
          rx_state_nxt   = RX_IDLE;
        end
      end
      RX_HOLD: begin
        rx_valid_nxt = 1'b1;
        if (rx_ready) begin
          rx_state_nxt = RX_IDLE;
          rx_valid_nxt = 1'b0;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state    <= RX_IDLE;
      pop         <= 1'b0;
      rx_valid    <= 1'b0;
      rx_src_bcst <= 1'b0;
      rx_payload  <= '0;
    end else begin
      rx_state    <= rx_state_nxt;
      pop         <= pop_nxt;
      rx_valid    <= rx_valid_nxt;
      rx_src_bcst <= rx_bcst_nxt;
      rx_payload  <= rx_payload_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_load)
      rx_buf <= D_pop;
  end

`ifdef BUS_EP_STATS_EN
  logic rx_pop_cyc;
  assign rx_pop_cyc = (rx_state == RX_POP);

  bus_ep_sat_cnt #(.W(STAT_W)) u_tx_cnt (
    .clk(clk), .clear(!reset), .inc(tx_accept), .cnt(tx_cnt)
  );
  bus_ep_sat_cnt #(.W(STAT_W)) u_rx_cnt (
    .clk(clk), .clear(!reset), .inc(rx_pop_cyc && rx_hit), .cnt(rx_cnt)
  );
  bus_ep_sat_cnt #(.W(STAT_W)) u_drop_cnt (
    .clk(clk), .clear(!reset), .inc(rx_pop_cyc && !rx_hit), .cnt(drop_cnt)
  );
`endif

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Bench for bus_dev_endpoint: directed plus randomized traffic against a cycle-timed reference model.
`define CHK(tag, obs, exp) begin vectors++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_bus_dev_endpoint;

  localparam int        BITS  = 65;
  localparam int        IDW   = 8;
  localparam int        PW    = BITS - IDW;
  localparam int        GAP   = 2;
  localparam logic [7:0] MY_ID = 8'h01;
  localparam logic [7:0] BC    = 8'hFF;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [IDW-1:0]  tx_dst = '0;
  logic [PW-1:0]   tx_payload = '0;
  logic            push;
  logic [BITS-1:0] D_push;
  logic            pndng = 1'b0;
  logic            pop;
  logic [BITS-1:0] D_pop = '0;
  logic            rx_valid;
  logic            rx_ready = 1'b0;
  logic            rx_src_bcst;
  logic [PW-1:0]   rx_payload;
`ifdef BUS_EP_STATS_EN
  logic [15:0]     tx_cnt, rx_cnt, drop_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bus_dev_endpoint #(.bits(BITS), .id_w(IDW), .id(MY_ID), .bdcst(BC), .gap(GAP)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst), .tx_payload(tx_payload),
    .push(push), .D_push(D_push),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src_bcst(rx_src_bcst), .rx_payload(rx_payload)
`ifdef BUS_EP_STATS_EN
    , .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt)
`endif
  );

  // Reference model: expected behaviour as edge-indexed times and held values
  int              cyc = 0;
  int              m_ready_from = 1 << 30;
  int              m_push_at = -1;
  int              m_pop_at = -1;
  int              m_rx_from = 1 << 30;
  logic [BITS-1:0] m_dpush = '0;
  logic [BITS-1:0] m_buf = '0;
  logic            m_valid = 1'b0;
  logic            m_bcst = 1'b0;
  logic [PW-1:0]   m_pay = '0;
  int              m_txc = 0, m_rxc = 0, m_dropc = 0;

  logic [BITS-1:0] busq[$];
  logic            pop_seen = 1'b0;
  int              push_pulses = 0;

  task automatic model_update();
    logic [7:0] d;
    cyc++;
    if (!reset) begin
      m_ready_from = cyc + 1;
      m_push_at    = -1;
      m_dpush      = '0;
      m_pop_at     = -1;
      m_rx_from    = cyc + 1;
      m_valid      = 1'b0;
      m_bcst       = 1'b0;
      m_pay        = '0;
      m_txc = 0; m_rxc = 0; m_dropc = 0;
    end else begin
      if (tx_valid && (cyc - 1 >= m_ready_from)) begin
        m_push_at    = cyc;
        m_dpush      = {tx_dst, tx_payload};
        m_ready_from = cyc + GAP + 1;
        if (m_txc < 65535) m_txc++;
      end
      if (m_valid) begin
        if (rx_ready) begin
          m_valid   = 1'b0;
          m_rx_from = cyc + 1;
        end
      end else if (m_pop_at == cyc - 1) begin
        d = m_buf[BITS-1 -: IDW];
        if (d == MY_ID || d == BC) begin
          m_valid = 1'b1;
          m_pay   = m_buf[PW-1:0];
          m_bcst  = (d == BC);
          if (m_rxc < 65535) m_rxc++;
        end else begin
          m_rx_from = cyc + 1;
          if (m_dropc < 65535) m_dropc++;
        end
      end else if (cyc >= m_rx_from && pndng) begin
        m_buf     = D_pop;
        m_pop_at  = cyc;
        m_rx_from = 1 << 30;
      end
    end
  endtask

  task automatic check_all();
    vectors++;
    if (tx_ready !== (cyc >= m_ready_from)) begin
      errors++;
      $error("FAIL tx_ready observed=%0h expected=%0h", tx_ready, (cyc >= m_ready_from));
    end
    vectors++;
    if (push !== (cyc == m_push_at)) begin
      errors++;
      $error("FAIL push observed=%0h expected=%0h", push, (cyc == m_push_at));
    end
    vectors++;
    if (D_push !== m_dpush) begin
      errors++;
      $error("FAIL D_push observed=%0h expected=%0h", D_push, m_dpush);
    end
    vectors++;
    if (pop !== (cyc == m_pop_at)) begin
      errors++;
      $error("FAIL pop observed=%0h expected=%0h", pop, (cyc == m_pop_at));
    end
    vectors++;
    if (rx_valid !== m_valid) begin
      errors++;
      $error("FAIL rx_valid observed=%0h expected=%0h", rx_valid, m_valid);
    end
    vectors++;
    if (rx_payload !== m_pay) begin
      errors++;
      $error("FAIL rx_payload observed=%0h expected=%0h", rx_payload, m_pay);
    end
    vectors++;
    if (rx_src_bcst !== m_bcst) begin
      errors++;
      $error("FAIL rx_src_bcst observed=%0h expected=%0h", rx_src_bcst, m_bcst);
    end
`ifdef BUS_EP_STATS_EN
    vectors++;
    if (tx_cnt !== 16'(m_txc)) begin
      errors++;
      $error("FAIL tx_cnt observed=%0h expected=%0h", tx_cnt, 16'(m_txc));
    end
    vectors++;
    if (rx_cnt !== 16'(m_rxc)) begin
      errors++;
      $error("FAIL rx_cnt observed=%0h expected=%0h", rx_cnt, 16'(m_rxc));
    end
    vectors++;
    if (drop_cnt !== 16'(m_dropc)) begin
      errors++;
      $error("FAIL drop_cnt observed=%0h expected=%0h", drop_cnt, 16'(m_dropc));
    end
`endif
  endtask

  task automatic drive_bus();
    pndng = (busq.size() > 0);
    D_pop = (busq.size() > 0) ? busq[0] : '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    if (pop_seen && busq.size() > 0) void'(busq.pop_front());
    @(negedge clk);
    check_all();
    pop_seen = (pop === 1'b1);
    if (push === 1'b1) push_pulses++;
    drive_bus();
  endtask

  function automatic logic [7:0] pick_dst();
    case ($urandom_range(0, 3))
      0:       return MY_ID;
      1:       return BC;
      2:       return 8'h03;
      default: return 8'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_push;

    // reset held for three cycles
    reset = 1'b0;
    repeat (3) step();
    `CHK("rst_tx_ready", tx_ready, 1'b0)
    `CHK("rst_push", push, 1'b0)
    `CHK("rst_pop", pop, 1'b0)
    `CHK("rst_rx_valid", rx_valid, 1'b0)
    `CHK("rst_D_push", D_push, {BITS{1'b0}})
    `CHK("rst_rx_payload", rx_payload, {PW{1'b0}})

    // single TX right after release
    reset = 1'b1;
    tx_valid = 1'b1; tx_dst = 8'h02; tx_payload = 57'h0ABC;
    step();
    `CHK("rel_tx_ready", tx_ready, 1'b1)
    step();
    `CHK("single_push", push, 1'b1)
    `CHK("single_D_push", D_push, {8'h02, 57'h0ABC})
    tx_valid = 1'b0;
    repeat (5) step();
`ifdef BUS_EP_STATS_EN
    `CHK("single_tx_cnt", tx_cnt, 16'd1)
`endif

    // TX pacing with tx_valid held for four packets
    push_pulses = 0;
    last_push = -1;
    tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_dst = pick_dst();
      tx_payload = PW'({$urandom(), $urandom()});
      step();
      if (push === 1'b1) begin
        if (last_push >= 0) `CHK("pace_gap", cyc - last_push, GAP + 2)
        last_push = cyc;
      end
    end
    tx_valid = 1'b0;
    repeat (3) step();
    `CHK("pace_count", push_pulses, 4)

    // RX match with user stall
    rx_ready = 1'b0;
    busq.push_back({8'h01, 57'h1234});
    drive_bus();
    step();
    `CHK("rxm_pop", pop, 1'b1)
    step();
    `CHK("rxm_valid", rx_valid, 1'b1)
    `CHK("rxm_payload", rx_payload, 57'h1234)
    `CHK("rxm_bcst", rx_src_bcst, 1'b0)
    repeat (5) step();
    `CHK("rxm_held", rx_valid, 1'b1)
    rx_ready = 1'b1;
    step();
    `CHK("rxm_cleared", rx_valid, 1'b0)

    // RX filter: foreign ID dropped, broadcast delivered
    busq.push_back({8'h03, 57'h0055});
    busq.push_back({8'hFF, 57'h0077});
    drive_bus();
    repeat (8) step();
    `CHK("rxf_last_payload", rx_payload, 57'h0077)
    `CHK("rxf_last_bcst", rx_src_bcst, 1'b1)

    // randomized concurrent TX and RX traffic
    for (int i = 0; i < 250; i++) begin
      tx_valid   = ($urandom_range(0, 1) == 1);
      tx_dst     = pick_dst();
      tx_payload = PW'({$urandom(), $urandom()});
      if ($urandom_range(0, 2) == 0 && busq.size() < 8)
        busq.push_back({pick_dst(), PW'({$urandom(), $urandom()})});
      rx_ready   = ($urandom_range(0, 2) != 0);
      drive_bus();
      step();
    end

    // reset while TX is pushing and RX is holding a packet
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    repeat (30) step();
    rx_ready = 1'b0;
    busq.push_back({MY_ID, PW'({$urandom(), $urandom()})});
    busq.push_back({BC, PW'({$urandom(), $urandom()})});
    drive_bus();
    repeat (4) step();
    tx_valid = 1'b1;
    tx_dst   = MY_ID;
    tx_payload = PW'({$urandom(), $urandom()});
    for (int i = 0; i < 12 && m_push_at != cyc; i++) step();
    tx_valid = 1'b0;
    reset = 1'b0;
    step();
    `CHK("midrst_push", push, 1'b0)
    `CHK("midrst_rx_valid", rx_valid, 1'b0)
    `CHK("midrst_pop", pop, 1'b0)
    step();
    reset = 1'b1;
    rx_ready = 1'b1;
    repeat (12) step();

    // drain
    for (int i = 0; i < 40; i++) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bus_dev_endpoint.md
Name: bus_dev_endpoint

Overview:
- Device-side endpoint for one node of the parallel bus (`prll_bs_ntrfs_riscv`).
- Drives that interface's push side (`push`, `D_push`) from a user valid/ready TX channel.
- Drains its pop side (`pndng`, `pop`, `D_pop`) into a user valid/ready RX channel.
- Filters received packets by destination ID. One instance per bus device, placed between device logic and the bus interface.

Parameters:
- bits, 65, packet width; must match the bus interface `bits`.
- id_w, 8, destination-ID field width, taken from the packet MSBs.
- id, 0, this node's ID (id_w bits).
- bdcst, {8{1'b1}}, broadcast ID (id_w bits).
- gap, 2, idle cycles forced after each push (0..255); paces pushes into the no-full interface FIFO.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- tx_valid  in  1  user TX request.
- tx_ready  out  1  TX accept.
- tx_dst  in  id_w  TX destination ID.
- tx_payload  in  bits-id_w  TX payload.
- push  out  1  push strobe to bus interface.
- D_push  out  bits  packet to bus interface.
- pndng  in  1  bus interface has a received packet; `D_pop` is valid while high (first-word fall-through).
- pop  out  1  pop strobe to bus interface.
- D_pop  in  bits  head packet from bus interface.
- rx_valid  out  1  received packet available.
- rx_ready  in  1  user RX accept.
- rx_src_bcst  out  1  held packet was broadcast.
- rx_payload  out  bits-id_w  held packet payload.
- Only with BUS_EP_STATS_EN: tx_cnt, rx_cnt, drop_cnt  out  16 each  statistics.

Behaviour:
- Packet format: `[bits-1 -: id_w]` = destination, `[bits-id_w-1:0]` = payload.
- Reset: reset==0 sampled at a clk edge does the following.
  - Outputs: push=0, D_push=0, pop=0, tx_ready=0, rx_valid=0, rx_payload=0, rx_src_bcst=0, counters=0.
  - FSMs go to TX_IDLE / RX_IDLE.
  - In-flight packets are discarded.
  - pop and push are never left high across reset.
  - tx_ready rises one cycle after reset releases.
- TX FSM: all outputs registered; TX and RX run independently.
  - TX_IDLE:
    - tx_ready=1.
    - On tx_valid&&tx_ready: D_push<={tx_dst,tx_payload}; next TX_PUSH.
  - TX_PUSH:
    - push=1 for exactly one cycle, D_push stable; tx_ready=0.
    - Next TX_GAP with counter=gap, or TX_IDLE if gap==0.
  - TX_GAP:
    - tx_ready=0, push=0, counter decrements.
    - Leaves for TX_IDLE in the cycle the counter reaches 1.
  - Throughput: one packet per gap+2 cycles; accept-to-push latency is 1 cycle.
  - D_push holds its last value outside TX_PUSH.
- RX FSM:
  - RX_IDLE:
    - If pndng=1: rx_buf<=D_pop; next RX_POP.
  - RX_POP:
    - pop=1 for exactly one cycle; pndng is ignored this cycle (stale).
    - Destination match = dst==id or dst==bdcst.
    - Match: rx_payload<=payload, rx_src_bcst<=(dst==bdcst); next RX_HOLD.
    - No match: drop, next RX_IDLE.
  - RX_HOLD:
    - rx_valid=1; payload held stable until rx_ready.
    - On rx_valid&&rx_ready: next RX_IDLE.
  - Latency: pndng sampled high in cycle N → pop high in N+1 → rx_valid high in N+2.
  - Back-to-back packets: next pop no earlier than 3 cycles after the previous one; a dropped packet allows the next pop in 2.
  - While the user stalls in RX_HOLD, no pops are issued and the bus interface buffers the packets.
  - bdcst==id is legal; rx_src_bcst=1 in that case.

Optional Feature:
- Macro: BUS_EP_STATS_EN.
- Defined:
  - tx_cnt increments on each push pulse.
  - rx_cnt increments on each matched packet in RX_POP.
  - drop_cnt increments on each unmatched packet.
  - All three are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: the counters and their ports do not exist; all other behaviour is identical.

Decomposition:
- Package `bus_ep_pkg`:
  - tx_state_e {TX_IDLE,TX_PUSH,TX_GAP}.
  - rx_state_e {RX_IDLE,RX_POP,RX_HOLD}.
  - Field-extract functions get_dst() and get_payload(), parameterised via id_w.
  - Constant STAT_W=16.
- Sub-module `bus_ep_sat_cnt` (saturating counter, inc/clear), instantiated three times under BUS_EP_STATS_EN.
- TX and RX FSMs stay in the top module.

Test Plan (defaults unless stated; id=1):
- Reset then single TX:
  - Stimulus: reset low 3 cycles, release; tx_valid=1, tx_dst=2, tx_payload=57'h0ABC.
  - Response: tx_ready=1 one cycle after release; push=1 for one cycle next cycle with D_push={8'h02,57'h0ABC}; tx_ready=0 for 3 cycles; tx_cnt=1.
- TX pacing:
  - Stimulus: tx_valid held high for 4 packets, gap=2.
  - Response: push pulses exactly 4 cycles apart, 4 pulses total.
- RX match:
  - Stimulus: pndng=1, D_pop={8'h01,57'h1234}.
  - Response: pop pulses one cycle later; rx_valid next cycle with rx_payload=57'h1234, rx_src_bcst=0; held through 5 cycles of rx_ready=0; cleared the cycle after rx_ready=1.
- RX filter:
  - Stimulus: D_pop dst=8'h03, then dst=8'hFF.
  - Response: first popped and dropped with rx_valid staying 0 and drop_cnt=1; second delivered with rx_src_bcst=1 and rx_cnt=1.
- Reset mid-operation:
  - Stimulus: assert reset during TX_PUSH and RX_HOLD.
  - Response: push, pop and rx_valid are 0 from the following edge; no further pop until pndng is resampled after release.
- Simultaneous TX/RX:
  - Stimulus: push a packet to dst=1 while pndng=1 with a packet for id 1.
  - Response: both complete with independent timing.
